shift_unit_arbiter: RTL
=======================

// Module: shift_unit_arbiter
// PURPOSE
//  Shares one ALU_barrel_shifter instance between NUM_REQ requesters (e.g. EX-stage ALU,
//  multi-cycle mul/div sequencer, CSR/bitmanip path). Round-robin arbitration with
//  valid/ready handshakes on both sides.
//  One-entry registered result slot: 1-cycle latency, 1 op/cycle sustained.
//  Result carries the requester index for return routing.
// PARAMETERS
//  NUM_REQ  2   number of requesters, >=2
//  ID_W     1   width of resp_id; must equal max(1,$clog2(NUM_REQ))
// PORTS
//  clk        in   1          rising-edge clock
//  rst        in   1          synchronous, active-high reset
//  req_valid  in   NUM_REQ    bit i: requester i presents an op
//  req_ready  out  NUM_REQ    bit i: op i accepted this cycle (one-hot or zero)
//  req_in     in   NUM_REQ*32 operand; requester i at [32*i+:32]
//  req_shamt  in   NUM_REQ*5  shift amount; requester i at [5*i+:5]
//  req_oper   in   NUM_REQ*2  00 rotl, 01 sll, 10 sra, 11 srl; requester i at [2*i+:2]
//  resp_valid out  1          result slot holds a valid result
//  resp_ready in   1          consumer takes result this cycle
//  resp_data  out  32         shifted result
//  resp_id    out  ID_W       index of requester that issued the result
// BEHAVIOUR
//  - Reset: resp_valid=0, resp_data=0, resp_id=0, rr_ptr=0; req_ready=0 during reset.
//  - Slot FSM: EMPTY/FULL (== resp_valid). can_accept = !resp_valid | resp_ready.
//  - Grant: combinational. First i with req_valid[i]=1, searched from rr_ptr upward
//    modulo NUM_REQ. req_ready[i]=1 only for the granted i and only if can_accept.
//    req_ready may depend on req_valid; requesters must not make valid depend on ready.
//  - Accept (any req_ready bit=1): at the next edge resp_data <= shifter(req_in[g],
//    req_shamt[g], req_oper[g]), resp_id <= g, resp_valid <= 1, rr_ptr <= (g+1) mod NUM_REQ.
//  - Drain without accept: resp_valid & resp_ready & no grant -> resp_valid <= 0;
//    resp_data/resp_id hold their last values.
//  - Simultaneous drain + accept: new result replaces old in the same edge; no bubble.
//  - Backpressure: resp_valid & !resp_ready -> req_ready=0, slot and rr_ptr hold.
//  - No request: rr_ptr holds.
//  - Latency: accept at edge N -> resp_valid at edge N+1. Throughput 1/cycle when
//    resp_ready=1.
//  - Fairness: a continuously valid requester is granted within NUM_REQ accepts.
//  - Shifter semantics: shamt 0 passes the operand through. Rotate wraps modulo 32.
//    sra replicates bit 31. Only shamt[4:0] is used.
//  - rst mid-operation: a pending result is dropped and is not re-issued.
//  - Requester valid deasserted without a handshake: the op is withdrawn; no state changes.
// STRUCTURE
//  - Shared package shift_pkg: SH_ROTL=2'b00, SH_SLL=2'b01, SH_SRA=2'b10, SH_SRL=2'b11.
//  - Operand mux and round-robin pick in this module.
//  - One sub-module instance: ALU_barrel_shifter (In/ShAmt/Oper/Out), fed by the granted
//    operand mux; its output is registered into the result slot.
// TESTING
//  1. Single op: req0 {In=32'h8000_0001, shamt=1, rotl}, resp_ready=1 -> next cycle
//     resp_data=32'h0000_0003, resp_id=0.
//  2. Contention: both valid for 4 cycles, rr_ptr=0 -> grant order 0,1,0,1; ops
//     0: sra 32'hF000_0000>>4 = 32'hFF00_0000; 1: srl 32'hF000_0000>>4 = 32'h0F00_0000.
//  3. Backpressure: resp_ready=0 for 3 cycles with slot FULL -> req_ready=0,
//     resp_data stable; ready rises -> next op is accepted in the same cycle.
//  4. Shift-amount boundaries: sll 32'h1 by 31 -> 32'h8000_0000; rotl by 0 returns
//     the operand; srl 32'hFFFF_FFFF by 31 -> 32'h1.
//  5. Reset with FULL slot and rr_ptr=1 -> resp_valid=0, rr_ptr=0; req1 and req0 both
//     valid after reset -> req0 is granted first.
//  6. Back-to-back throughput: 8 ops from req1 with resp_ready=1 -> 8 results on
//     consecutive cycles with no bubbles, in order, all resp_id=1.

Source files
------------

// File: rtl/shift_pkg.sv
// Shared types and constants for the shift unit and its arbiter.
package shift_pkg;

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned SHAMT_W = 5;
    localparam int unsigned OPER_W  = 2;

    typedef enum logic [OPER_W-1:0] {
        SH_ROTL = 2'b00,
        SH_SLL  = 2'b01,
        SH_SRA  = 2'b10,
        SH_SRL  = 2'b11
    } shift_op_e;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_e;

    // One shift operation as presented to the shared shifter.
    typedef struct packed {
        logic [DATA_W-1:0]  data;
        logic [SHAMT_W-1:0] shamt;
        shift_op_e          oper;
    } shift_req_t;

endpackage

// File: rtl/ALU_barrel_shifter.sv
// Combinational 32-bit barrel shifter: rotate-left, sll, sra, srl.
// Ports:
//   In    - operand
//   ShAmt - shift amount (5 bits, modulo 32)
//   Oper  - operation select
//   Out   - shifted result
module ALU_barrel_shifter
    import shift_pkg::*;
(
    input  logic [DATA_W-1:0]  In,
    input  logic [SHAMT_W-1:0] ShAmt,
    input  shift_op_e          Oper,
    output logic [DATA_W-1:0]  Out
);

    logic [2*DATA_W-1:0] rot_wide;

    // Rotate: shift the doubled operand, the upper half holds the wrapped result.
    always_comb begin
        rot_wide = {In, In} << ShAmt;
        Out      = In;
        case (Oper)
            SH_ROTL: Out = rot_wide[2*DATA_W-1:DATA_W];
            SH_SLL:  Out = In << ShAmt;
            SH_SRA:  Out = DATA_W'($signed(In) >>> ShAmt);
            SH_SRL:  Out = In >> ShAmt;
            default: Out = In;
        endcase
    end

endmodule

// File: rtl/shift_unit_arbiter.sv
// Round-robin arbiter sharing one barrel shifter between NUM_REQ requesters,
// with a one-entry registered result slot (1-cycle latency, 1 op/cycle).
// Ports:
//   clk, rst                 - clock, synchronous active-high reset
//   req_valid/req_ready      - per-requester handshake (ready is one-hot or zero)
//   req_in/req_shamt/req_oper- packed per-requester operands
//   resp_valid/resp_ready    - result slot handshake
//   resp_data/resp_id        - shifted result and issuing requester index
module shift_unit_arbiter
    import shift_pkg::*;
#(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned ID_W    = 1
)(
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_REQ-1:0]           req_valid,
    output logic [NUM_REQ-1:0]           req_ready,
    input  logic [NUM_REQ*DATA_W-1:0]    req_in,
    input  logic [NUM_REQ*SHAMT_W-1:0]   req_shamt,
    input  logic [NUM_REQ*OPER_W-1:0]    req_oper,
    output logic                         resp_valid,
    input  logic                         resp_ready,
    output logic [DATA_W-1:0]            resp_data,
    output logic [ID_W-1:0]              resp_id
);

    slot_state_e       state_q, state_d;
    logic [ID_W-1:0]   rr_ptr;
    logic [ID_W-1:0]   grant_idx;
    logic [ID_W-1:0]   rr_next;
    logic              grant_vld;
    logic              can_accept;
    logic              accept;
    shift_req_t        sel_req;
    logic [DATA_W-1:0] shift_out;

    assign resp_valid = (state_q == SLOT_FULL);
    assign can_accept = (state_q == SLOT_EMPTY) | resp_ready;
    assign accept     = grant_vld & can_accept & ~rst;
    assign rr_next    = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + ID_W'(1);

    // Round-robin pick: first pass from rr_ptr upward, second pass wraps to 0.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!grant_vld && req_valid[i] && (ID_W'(i) >= rr_ptr)) begin
                grant_vld = 1'b1;
                grant_idx = ID_W'(i);
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!grant_vld && req_valid[i]) begin
                grant_vld = 1'b1;
                grant_idx = ID_W'(i);
            end
        end
    end

    // Operand mux for the granted requester and one-hot ready.
    always_comb begin
        sel_req   = '0;
        req_ready = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_idx == ID_W'(i)) begin
                sel_req.data  = req_in[DATA_W*i +: DATA_W];
                sel_req.shamt = req_shamt[SHAMT_W*i +: SHAMT_W];
                sel_req.oper  = shift_op_e'(req_oper[OPER_W*i +: OPER_W]);
                req_ready[i]  = accept;
            end
        end
    end

    ALU_barrel_shifter u_shifter (
        .In    (sel_req.data),
        .ShAmt (sel_req.shamt),
        .Oper  (sel_req.oper),
        .Out   (shift_out)
    );

    // Slot state register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= SLOT_EMPTY;
        else     state_q <= state_d;
    end

    // Slot next-state: accept fills (replacing on drain), drain alone empties.
    always_comb begin
        state_d = state_q;
        if (accept)          state_d = SLOT_FULL;
        else if (resp_ready) state_d = SLOT_EMPTY;
    end

    // Result payload and round-robin pointer; both hold unless an op is accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            resp_data <= '0;
            resp_id   <= '0;
            rr_ptr    <= '0;
        end else if (accept) begin
            resp_data <= shift_out;
            resp_id   <= grant_idx;
            rr_ptr    <= rr_next;
        end
    end

endmodule
